// File: rtl/wb_master.sv
// wb_master: command/response front end for a classic single-beat Wishbone
// initiator. Commands queue in a small FIFO; each one becomes one Wishbone
// cycle. The cycle ends on ack or after a fixed number of cycles without one.
//
// Handshakes: a command transfers on any rising edge where i_cmd_valid and
// o_cmd_ready are both high. Valid may arrive before ready; the command is
// only taken when ready is high. There is no response back-pressure:
// o_rsp_valid is a one-cycle pulse that the host must capture when it sees it.
module wb_master #(
  parameter int mem_width  = 16,
  parameter int adr_width  = 16,
  parameter int fifo_depth = 4,
  parameter int timeout    = 16
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [adr_width-1:0] i_cmd_adr,
  input  logic [mem_width-1:0] i_cmd_data,
  output logic                 o_rsp_valid,
  output logic [mem_width-1:0] o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [adr_width-1:0] o_wb_adr,
  output logic [mem_width-1:0] o_wb_data,
  input  logic [mem_width-1:0] i_wb_data,
  input  logic                 i_wb_ack,
  output logic                 o_busy,
  output logic                 o_dbg_state
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam int tmr_w = $clog2(timeout);
  localparam int ent_w = 1 + adr_width + mem_width;

  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(fifo_depth);
  localparam logic [tmr_w-1:0] tmr_last = tmr_w'(timeout - 1);

  typedef enum logic {
    st_idle = 1'b0,
    st_wait = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Command FIFO storage and bookkeeping
  logic [ent_w-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [ent_w-1:0]     head;
  logic                 head_we;
  logic [adr_width-1:0] head_adr;
  logic [mem_width-1:0] head_data;

  // Wait counter and next values of the registered outputs
  logic [tmr_w-1:0]     wait_cnt;
  logic [tmr_w-1:0]     wait_cnt_d;
  logic                 tmr_hit;
  logic                 cyc_d;
  logic                 we_d;
  logic [adr_width-1:0] adr_d;
  logic [mem_width-1:0] wdata_d;
  logic                 rsp_valid_d;
  logic                 rsp_err_d;
  logic [mem_width-1:0] rsp_data_d;

  assign full  = (count == cnt_full);
  assign empty = (count == '0);
  // A full FIFO drops the push because ready is already low.
  assign push  = i_cmd_valid & ~full;
  // Only pop when a command is actually stored before this edge.
  assign pop   = (state_q == st_idle) & ~empty;

  assign head      = fifo_mem[rd_ptr];
  assign head_we   = head[ent_w-1];
  assign head_adr  = head[mem_width +: adr_width];
  assign head_data = head[mem_width-1:0];

  assign tmr_hit = (wait_cnt == tmr_last);

  assign o_cmd_ready = ~full;
  assign o_busy      = ~empty | (state_q == st_wait);
  assign o_dbg_state = state_q;

  // FIFO entry write; storage needs no reset because count guards reads
  always_ff @(posedge i_wb_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {i_cmd_we, i_cmd_adr, i_cmd_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) state_q <= st_idle;
    else          state_q <= state_d;
  end

  // Next-state: start a cycle when work is queued, finish on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: if (!empty)             state_d = st_wait;
      st_wait: if (i_wb_ack || tmr_hit) state_d = st_idle;
      default:                         state_d = st_idle;
    endcase
  end

  // Output next values: load bus from FIFO head, build response on completion
  always_comb begin
    cyc_d       = o_wb_cyc;
    we_d        = o_wb_we;
    adr_d       = o_wb_adr;
    wdata_d     = o_wb_data;
    wait_cnt_d  = wait_cnt;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    case (state_q)
      st_idle: begin
        if (!empty) begin
          cyc_d      = 1'b1;
          we_d       = head_we;
          adr_d      = head_adr;
          wdata_d    = head_data;
          wait_cnt_d = '0;
        end
      end
      st_wait: begin
        if (i_wb_ack) begin
          // Ack wins even on the timeout edge.
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = o_wb_we ? '0 : i_wb_data;
        end else if (tmr_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      default: cyc_d = 1'b0;
    endcase
  end

  // Registered Wishbone and response outputs
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_adr    <= '0;
      o_wb_data   <= '0;
      wait_cnt    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_wb_cyc    <= cyc_d;
      o_wb_stb    <= cyc_d;
      o_wb_we     <= we_d;
      o_wb_adr    <= adr_d;
      o_wb_data   <= wdata_d;
      wait_cnt    <= wait_cnt_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_err   <= rsp_err_d;
      o_rsp_data  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed test of wb_master against a transaction-level model
// (command queue, one in-flight record, age in cycles) plus a response
// scoreboard filled with hand-computed expectations.
module tb_wb_master;
  localparam int MW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_adr;
  logic [MW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic [MW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_adr;
  logic [MW-1:0] o_wb_data;
  logic [MW-1:0] i_wb_data;
  logic          i_wb_ack;
  logic          o_busy;
  logic          o_dbg_state;

  wb_master #(
    .mem_width(MW), .adr_width(AW), .fifo_depth(DEPTH), .timeout(TMO)
  ) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
    .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard of expected responses {err, data}
  logic [MW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW+MW:0] m_q[$];
  bit             m_busy;
  int             m_age;
  bit             m_acc;
  logic           m_we;
  logic [AW-1:0]  m_adr;
  logic [MW-1:0]  m_data;
  logic           m_rv;
  logic           m_re;
  logic [MW-1:0]  m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_busy = 0; m_age = 0;
      m_we = 0; m_adr = '0; m_data = '0;
      m_rv = 0; m_re = 0; m_rd = '0;
    end else begin
      m_acc = i_cmd_valid && (m_q.size() < DEPTH);
      m_rv = 0; m_re = 0; m_rd = '0;
      if (!m_busy) begin
        if (m_q.size() > 0) begin
          {m_we, m_adr, m_data} = m_q.pop_front();
          m_busy = 1;
          m_age  = 1;
        end
      end else if (i_wb_ack) begin
        m_rv = 1;
        m_rd = m_we ? '0 : i_wb_data;
        m_busy = 0;
      end else if (m_age == TMO) begin
        m_rv = 1; m_re = 1;
        m_busy = 0;
      end else begin
        m_age++;
      end
      if (m_acc) m_q.push_back({i_cmd_we, i_cmd_adr, i_cmd_data});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("cyc", o_wb_cyc, m_busy);
    check("stb", o_wb_stb, m_busy);
    check("dbg_state", o_dbg_state, m_busy);
    check("wb_we", o_wb_we, m_we);
    check("wb_adr", o_wb_adr, m_adr);
    check("wb_data", o_wb_data, m_data);
    check("rsp_valid", o_rsp_valid, m_rv);
    check("rsp_err", o_rsp_err, m_re);
    check("rsp_data", o_rsp_data, m_rd);
    check("cmd_ready", o_cmd_ready, m_q.size() < DEPTH);
    check("busy", o_busy, (m_q.size() > 0) || m_busy);
    if (o_rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else check("rsp_sb", {o_rsp_err, o_rsp_data}, exp_q.pop_front());
    end
  end

  // ---------------- slave responder ----------------
  int          ack_delay = 0;
  bit          stray_ack = 0;
  logic [MW-1:0] rdata = 16'hBEEF;
  int          stb_len = 0;
  int          last_len = 0;

  initial begin
    i_wb_ack  = 1'b0;
    i_wb_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (o_wb_stb) stb_len++;
      else begin
        if (stb_len != 0) last_len = stb_len;
        stb_len = 0;
      end
      i_wb_ack  = (o_wb_stb && ack_delay != 0 && stb_len >= ack_delay) ||
                  (!o_wb_cyc && stray_ack);
      i_wb_data = rdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic we, input logic [AW-1:0] adr, input logic [MW-1:0] data);
    bit done = 0;
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_adr   = adr;
    i_cmd_data  = data;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = o_cmd_ready;
      @(posedge clk);
      #2;
    end
    if (!done) check("push_accept", 0, 1);
  endtask

  task automatic cmd_idle();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 0;
    for (int k = 0; k < max_cycles && !ok; k++) begin
      @(negedge clk);
      ok = !o_busy;
    end
    check("wait_idle", ok, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we = 1'b0;
    i_cmd_adr = '0;
    i_cmd_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_adr", o_wb_adr, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Single write, slave acks in the second stb cycle
    ack_delay = 2;
    exp_q.push_back({1'b0, 16'h0000});
    push_cmd(1'b1, 16'h0001, 16'h00FF);
    cmd_idle();
    wait_idle(50);
    check("wr_stb_len", last_len, 2);

    // Read returns slave data
    ack_delay = 1;
    rdata = 16'h1234;
    exp_q.push_back({1'b0, 16'h1234});
    push_cmd(1'b0, 16'h0003, 16'h0000);
    cmd_idle();
    wait_idle(50);
    check("rd_stb_len", last_len, 1);

    // Stray ack while idle must be ignored
    stray_ack = 1;
    repeat (3) @(posedge clk);
    #2;
    stray_ack = 0;
    repeat (2) @(posedge clk);
    #2;

    // Fill: one in flight plus four queued, then a dropped push
    ack_delay = 0;
    rdata = 16'h0C0D;
    for (int i = 0; i < 5; i++) begin
      logic w;
      w = (i % 2 == 0);
      exp_q.push_back({1'b0, w ? 16'h0000 : 16'h0C0D});
      push_cmd(w, 16'h0010 + 16'(i), 16'h00A0 + 16'(i));
    end
    cmd_idle();
    check("full_ready", o_cmd_ready, 0);
    check("full_busy", o_busy, 1);
    i_cmd_valid = 1'b1;
    i_cmd_we = 1'b1;
    i_cmd_adr = 16'h00EE;
    i_cmd_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #2;
    cmd_idle();
    ack_delay = 1;
    wait_idle(200);

    // Timeout with no ack
    ack_delay = 0;
    exp_q.push_back({1'b1, 16'h0000});
    push_cmd(1'b1, 16'h0020, 16'h5A5A);
    cmd_idle();
    wait_idle(100);
    check("tmo_stb_len", last_len, 16);

    // Ack on the timeout cycle wins
    ack_delay = 16;
    rdata = 16'h4321;
    exp_q.push_back({1'b0, 16'h4321});
    push_cmd(1'b0, 16'h0021, 16'h0000);
    cmd_idle();
    wait_idle(100);
    check("tmo_ack_stb_len", last_len, 16);

    // Reset mid-cycle with two queued commands
    ack_delay = 0;
    push_cmd(1'b1, 16'h0030, 16'h1111);
    push_cmd(1'b1, 16'h0031, 16'h2222);
    push_cmd(1'b1, 16'h0032, 16'h3333);
    cmd_idle();
    repeat (2) @(posedge clk);
    #2;
    check("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", o_wb_cyc, 0);
    check("mid_rst_stb", o_wb_stb, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_cmd_ready, 1);
    check("mid_rst_adr", o_wb_adr, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("post_rst_busy", o_busy, 0);
    check("post_rst_cyc", o_wb_cyc, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
